// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding imem fetch at a time,
// and feeds opcode/next-address pairs to IF/ID through a one-entry skid buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] entireOpCode_out,
  output logic [31:0] newAddress_out,
  output logic        valid_out
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] op_d, naddr_d;
  logic            valid_d;
  logic [XLEN-1:0] skid_op_q, skid_op_d;
  logic [XLEN-1:0] skid_addr_q, skid_addr_d;
  logic            skid_v_q, skid_v_d;

  logic            grant;
  logic            xfer;
  logic            slot_free;
  logic [XLEN-1:0] resp_addr;

  // Requests stop while the skid buffer is occupied, and are forced low in reset.
  assign imem_req  = !RST && (state_q == S_FETCH) && !skid_v_q;
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  assign xfer      = valid_out && !stall;
  assign slot_free = !valid_out || xfer;
  assign resp_addr = req_pc_q + ADDR_STEP;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q          <= S_FETCH;
      pc_q             <= RESET_PC;
      req_pc_q         <= '0;
      entireOpCode_out <= '0;
      newAddress_out   <= '0;
      valid_out        <= 1'b0;
      skid_op_q        <= '0;
      skid_addr_q      <= '0;
      skid_v_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      req_pc_q         <= req_pc_d;
      entireOpCode_out <= op_d;
      newAddress_out   <= naddr_d;
      valid_out        <= valid_d;
      skid_op_q        <= skid_op_d;
      skid_addr_q      <= skid_addr_d;
      skid_v_q         <= skid_v_d;
    end
  end

  // Next-state and datapath; redirect overrides everything else.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    op_d        = entireOpCode_out;
    naddr_d     = newAddress_out;
    valid_d     = valid_out;
    skid_op_d   = skid_op_q;
    skid_addr_d = skid_addr_q;
    skid_v_d    = skid_v_q;

    if (redirect) begin
      pc_d     = redirect_addr;
      valid_d  = 1'b0;
      skid_v_d = 1'b0;
      unique case (state_q)
        S_FETCH: state_d = grant ? S_DRAIN : S_FETCH;
        S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DRAIN;
        S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
        default: state_d = S_FETCH;
      endcase
    end else begin
      if (xfer) valid_d = 1'b0;
      // Skid entry is older than any response arriving now, so it goes first.
      if (slot_free && skid_v_q) begin
        op_d     = skid_op_q;
        naddr_d  = skid_addr_q;
        valid_d  = 1'b1;
        skid_v_d = 1'b0;
      end
      unique case (state_q)
        S_FETCH: begin
          if (grant) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_STEP;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (slot_free && !skid_v_q) begin
              op_d    = imem_rdata;
              naddr_d = resp_addr;
              valid_d = 1'b1;
            end else begin
              skid_op_d   = imem_rdata;
              skid_addr_d = resp_addr;
              skid_v_d    = 1'b1;
            end
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming/stall vector table plus redirect,
// wrap-around and async-reset sequences against a simple latency-programmable memory.
module tb_if_fetch_unit;

  localparam logic [31:0] MASK = 32'hA5A5_A5A5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] entireOpCode_out;
  logic [31:0] newAddress_out;
  logic        valid_out;

  int checks = 0;
  int failures = 0;

  int          mem_lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;

  if_fetch_unit dut (
    .CLK(CLK), .RST(RST), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .entireOpCode_out(entireOpCode_out), .newAddress_out(newAddress_out),
    .valid_out(valid_out)
  );

  always #5 CLK = ~CLK;

  // Memory: sees the request mid-cycle, answers mem_lat cycles after the grant edge.
  always @(negedge CLK) begin
    imem_rvalid = 1'b0;
    if (RST) begin
      pend = 1'b0;
    end else begin
      if (pend && cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr ^ MASK;
        pend        = 1'b0;
      end else if (pend) begin
        cnt = cnt - 1;
      end
      if (imem_req && imem_gnt) begin
        pend      = 1'b1;
        cnt       = mem_lat;
        pend_addr = imem_addr;
      end
    end
  end

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] op;
    logic [31:0] na;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    repeat (2) step();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_op", entireOpCode_out, 32'd0);
    chk("rst_naddr", newAddress_out, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    RST = 1'b0;
    #1;
  endtask

  task automatic wait_req(input int max);
    for (int i = 0; i < max && !imem_req; i++) step();
    chk("wait_req_timeout", 32'(imem_req), 32'd1);
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !valid_out; i++) step();
    chk("wait_valid_timeout", 32'(valid_out), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'hA5A5_A5A5, 32'h04};
    tbl[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'hA5A5_A5A1, 32'h08};
    tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'hA5A5_A5AD, 32'h0C};
    tbl[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'hA5A5_A5AD, 32'h0C};
    tbl[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'hA5A5_A5AD, 32'h0C};
    tbl[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'hA5A5_A5AD, 32'h0C};
    tbl[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'hA5A5_A5AD, 32'h0C};
    tbl[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'hA5A5_A5AD, 32'h0C};
    tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'hA5A5_A5AD, 32'h0C};
    tbl[13] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hA5A5_A5A9, 32'h10};
    tbl[14] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0};
    tbl[15] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'hA5A5_A5B5, 32'h14};

    // Streaming and stall/skid behaviour, one record per cycle after reset.
    mem_lat = 1;
    imem_gnt = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].stall;
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_op", i), entireOpCode_out, tbl[i].op);
        chk($sformatf("tbl%0d_naddr", i), newAddress_out, tbl[i].na);
      end
      step();
    end
    stall = 1'b0;

    // Redirect while waiting on a 3-cycle response: stale data must be drained.
    mem_lat = 3;
    do_reset();
    step();
    redirect = 1'b1;
    redirect_addr = 32'h0000_0100;
    step();
    redirect = 1'b0;
    mem_lat = 1;
    chk("drain_valid_n1", 32'(valid_out), 32'd0);
    chk("drain_req_c2", 32'(imem_req), 32'd0);
    step();
    chk("drain_req_c3", 32'(imem_req), 32'd0);
    chk("drain_valid_c3", 32'(valid_out), 32'd0);
    wait_req(6);
    chk("drain_next_addr", imem_addr, 32'h0000_0100);
    wait_valid(6);
    chk("drain_op", entireOpCode_out, 32'hA5A5_A4A5);
    chk("drain_naddr", newAddress_out, 32'h0000_0104);

    // Redirect in the same cycle as the response: that data is dropped.
    mem_lat = 1;
    do_reset();
    step();
    redirect = 1'b1;
    redirect_addr = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("rvred_valid", 32'(valid_out), 32'd0);
    chk("rvred_req", 32'(imem_req), 32'd1);
    chk("rvred_addr", imem_addr, 32'h0000_0200);
    step();
    chk("rvred_valid_c3", 32'(valid_out), 32'd0);
    step();
    chk("rvred_valid_c4", 32'(valid_out), 32'd1);
    chk("rvred_op", entireOpCode_out, 32'hA5A5_A7A5);
    chk("rvred_naddr", newAddress_out, 32'h0000_0204);

    // PC wrap-around at the top of the address space.
    imem_gnt = 1'b0;
    do_reset();
    chk("wrap_req0", 32'(imem_req), 32'd1);
    redirect = 1'b1;
    redirect_addr = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    chk("wrap_req1", 32'(imem_req), 32'd1);
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("wrap_valid", 32'(valid_out), 32'd1);
    chk("wrap_op", entireOpCode_out, 32'h5A5A_5A59);
    chk("wrap_naddr", newAddress_out, 32'h0000_0000);
    chk("wrap_next_req", 32'(imem_req), 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);

    // Asynchronous reset while a slow fetch is outstanding.
    mem_lat = 1;
    do_reset();
    step();
    step();
    stall = 1'b1;
    mem_lat = 3;
    step();
    chk("arst_pre_valid", 32'(valid_out), 32'd1);
    chk("arst_pre_op", entireOpCode_out, 32'hA5A5_A5A5);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_op", entireOpCode_out, 32'd0);
    chk("arst_naddr", newAddress_out, 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    stall = 1'b0;
    mem_lat = 1;
    do_reset();
    chk("arst_first_req", 32'(imem_req), 32'd1);
    chk("arst_first_addr", imem_addr, 32'h0000_0000);
    wait_valid(6);
    chk("arst_first_op", entireOpCode_out, 32'hA5A5_A5A5);
    chk("arst_first_naddr", newAddress_out, 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
